instr_fetch_unit: RTL and testbench

Instruction fetch (IF) stage of the 5-stage CPU. Owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and loads the IF/ID pipeline register whose `opcode` field feeds the control unit. It consumes the control unit's `jump_or_branch` encoding from downstream to redirect the PC and flush wrong-path instructions, and it honours the hazard unit's stall.

---
 rtl/instr_fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over imem req/ack, loads IF/ID, flushes on jump/taken branch.
// Latency: IF/ID loads on the edge that completes the imem transfer; redirect empties IF/ID on the next edge.
// Backpressure: stall parks one fetched word in a skid buffer and drops imem_req; IFU_PERF_CNT_EN adds counters.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [1:0]        jump_or_branch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] target_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [5:0]        opcode
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       squash_cnt
`endif
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_SQUASH = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] sq_addr_q, sq_addr_d;
    logic              active_q;
    logic              ifid_vld_q, ifid_vld_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic redirect;
    logic xfer;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic        fetch_inc;
    logic [1:0]  drop_n;
`endif

    // active_q keeps imem_req low until the first edge after reset release.
    always_comb begin
        redirect  = (jump_or_branch == 2'b10) ||
                    ((jump_or_branch == 2'b01) && branch_taken);
        imem_req  = active_q && (state_q != ST_FULL);
        imem_addr = (state_q == ST_SQUASH) ? sq_addr_q : pc_q;
        xfer      = imem_req && imem_ack;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sq_addr_d    = sq_addr_q;
        ifid_vld_d   = ifid_vld_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
`ifdef IFU_PERF_CNT_EN
        fetch_inc    = 1'b0;
        drop_n       = 2'd0;
`endif
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = 32'h0;
                    pc_d         = target_addr;
                    // A request already on the bus cannot be withdrawn.
                    if (imem_req && !imem_ack) begin
                        state_d   = ST_SQUASH;
                        sq_addr_d = pc_q;
                    end
`ifdef IFU_PERF_CNT_EN
                    drop_n = {1'b0, ifid_vld_q} + {1'b0, xfer};
`endif
                end else if (xfer) begin
                    pc_d = pc_q + PC_ONE;
                    if (stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = ST_FULL;
                    end else begin
                        ifid_vld_d   = 1'b1;
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = pc_q;
`ifdef IFU_PERF_CNT_EN
                        fetch_inc = 1'b1;
`endif
                    end
                end
            end
            ST_SQUASH: begin
                if (redirect) begin
                    pc_d = target_addr;
                end
                if (xfer) begin
                    state_d = ST_FETCH;
`ifdef IFU_PERF_CNT_EN
                    drop_n = 2'd1;
`endif
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    ifid_vld_d   = 1'b0;
                    ifid_instr_d = 32'h0;
                    pc_d         = target_addr;
                    state_d      = ST_FETCH;
`ifdef IFU_PERF_CNT_EN
                    drop_n = {1'b0, ifid_vld_q} + 2'd1;
`endif
                end else if (!stall) begin
                    ifid_vld_d   = 1'b1;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    state_d      = ST_FETCH;
`ifdef IFU_PERF_CNT_EN
                    fetch_inc = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

`ifdef IFU_PERF_CNT_EN
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {15'd0, fetch_inc};
        squash_cnt_d = squash_cnt_q + {14'd0, drop_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 16'd0;
            squash_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            sq_addr_q    <= RESET_PC;
            active_q     <= 1'b0;
            ifid_vld_q   <= 1'b0;
            ifid_instr_q <= 32'h0;
            ifid_pc_q    <= '0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sq_addr_q    <= sq_addr_d;
            active_q     <= 1'b1;
            ifid_vld_q   <= ifid_vld_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign if_id_valid = ifid_vld_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_pc    = ifid_pc_q;
    assign opcode      = ifid_instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: transaction-level model checked every cycle plus literal pins.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  jump_or_branch;
    logic        branch_taken;
    logic [15:0] target_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [5:0]  opcode;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] squash_cnt;
`endif

    int tests = 0;
    int fails = 0;

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .jump_or_branch (jump_or_branch),
        .branch_taken   (branch_taken),
        .target_addr    (target_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .opcode         (opcode)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: opcode field = addr[5:0]+3, low half = address.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [5:0] op;
        op = a[5:0] + 6'd3;
        return {op, 10'h000, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: next PC, abandoned request, skid occupancy and IF/ID contents.
    logic        m_active, m_drop_pend, m_skid_v, m_v;
    logic [15:0] m_pc, m_drop_addr, m_skid_pc, m_ipc;
    logic [31:0] m_instr;
    int          m_fcnt, m_scnt;

    task automatic model_step();
        logic redir, req, x;
        if (!rst_n) begin
            m_active = 1'b0; m_drop_pend = 1'b0; m_skid_v = 1'b0; m_v = 1'b0;
            m_pc = 16'h0; m_drop_addr = 16'h0; m_skid_pc = 16'h0; m_ipc = 16'h0;
            m_instr = 32'h0; m_fcnt = 0; m_scnt = 0;
        end else begin
            redir = (jump_or_branch == 2'b10) || (jump_or_branch == 2'b01 && branch_taken);
            req   = m_active && !m_skid_v;
            x     = req && imem_ack;
            if (redir) begin
                m_scnt += int'(m_v) + int'(m_skid_v) + int'(x);
                m_v = 1'b0; m_instr = 32'h0; m_skid_v = 1'b0;
                if (x) m_drop_pend = 1'b0;
                else if (req && !m_drop_pend) begin
                    m_drop_pend = 1'b1;
                    m_drop_addr = m_pc;
                end
                m_pc = target_addr;
            end else if (m_drop_pend) begin
                if (x) begin
                    m_drop_pend = 1'b0;
                    m_scnt++;
                end
            end else if (m_skid_v) begin
                if (!stall) begin
                    m_v = 1'b1; m_ipc = m_skid_pc; m_instr = mem_word(m_skid_pc);
                    m_skid_v = 1'b0; m_fcnt++;
                end
            end else if (x) begin
                if (stall) begin
                    m_skid_v = 1'b1; m_skid_pc = m_pc;
                end else begin
                    m_v = 1'b1; m_ipc = m_pc; m_instr = mem_word(m_pc); m_fcnt++;
                end
                m_pc = m_pc + 16'd1;
            end
            m_active = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("req", 32'(imem_req), 32'(m_active && !m_skid_v));
                if (m_active && !m_skid_v)
                    chk("addr", 32'(imem_addr), 32'(m_drop_pend ? m_drop_addr : m_pc));
                chk("valid", 32'(if_id_valid), 32'(m_v));
                chk("instr", if_id_instr, m_instr);
                chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
                if (m_v) chk("ifid_pc", 32'(if_id_pc), 32'(m_ipc));
`ifdef IFU_PERF_CNT_EN
                chk("fetch_cnt", 32'(fetch_cnt), 32'(m_fcnt[15:0]));
                chk("squash_cnt", 32'(squash_cnt), 32'(m_scnt[15:0]));
`endif
            end
        end
    end

    task automatic step(input logic s, input logic [1:0] j, input logic b,
                        input logic [15:0] t, input logic a);
        stall = s; jump_or_branch = j; branch_taken = b; target_addr = t; imem_ack = a;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_instr"}, if_id_instr, 32'h0);
        chk({tag, "_pc"}, 32'(if_id_pc), 32'h0);
        chk({tag, "_opcode"}, 32'(opcode), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jump_or_branch = 2'b00; branch_taken = 1'b0;
        target_addr = 16'h0; imem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Zero-wait sequential fetch.
        step(0, 2'b00, 0, 16'h0, 1);
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", 32'(imem_addr), 32'h0);
        for (int i = 0; i < 6; i++) step(0, 2'b00, 0, 16'h0, 1);
        chk("seq_pc5", 32'(if_id_pc), 32'h5);
        chk("seq_instr5", if_id_instr, 32'h2000_0005);
        chk("seq_opcode5", 32'(opcode), 32'h8);
        chk("seq_addr6", 32'(imem_addr), 32'h6);

        // Jump to 0x40.
        step(0, 2'b10, 0, 16'h0040, 1);
        chk("jmp_valid", 32'(if_id_valid), 32'h0);
        chk("jmp_instr", if_id_instr, 32'h0);
        chk("jmp_addr", 32'(imem_addr), 32'h40);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("jmp_load", if_id_instr, 32'h0C00_0040);

        // Branch not taken, taken, and the 11 encoding.
        step(0, 2'b01, 0, 16'h0099, 1);
        chk("bnt_valid", 32'(if_id_valid), 32'h1);
        chk("bnt_pc", 32'(if_id_pc), 32'h41);
        step(0, 2'b01, 1, 16'h0010, 1);
        chk("bt_valid", 32'(if_id_valid), 32'h0);
        chk("bt_addr", 32'(imem_addr), 32'h10);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("bt_load", if_id_instr, 32'h4C00_0010);
        step(0, 2'b11, 1, 16'h0099, 1);
        chk("jb11_pc", 32'(if_id_pc), 32'h11);

        // Slow memory: redirect while request at 0x8 is pending.
        step(0, 2'b10, 0, 16'h0008, 1);
        step(0, 2'b10, 0, 16'h0030, 0);
        chk("sq_req", 32'(imem_req), 32'h1);
        chk("sq_addr", 32'(imem_addr), 32'h8);
        step(0, 2'b10, 0, 16'h0020, 0);
        chk("sq_hold", 32'(imem_addr), 32'h8);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("sq_next", 32'(imem_addr), 32'h20);
        chk("sq_nolo", 32'(if_id_valid), 32'h0);
        step(0, 2'b00, 0, 16'h0, 0);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("sq_load", if_id_instr, 32'h8C00_0020);

        // Stall as the word for pc 7 arrives.
        step(0, 2'b10, 0, 16'h0006, 1);
        step(0, 2'b00, 0, 16'h0, 1);
        step(1, 2'b00, 0, 16'h0, 1);
        chk("stl_req", 32'(imem_req), 32'h0);
        chk("stl_pc", 32'(if_id_pc), 32'h6);
        for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 16'h0, 1);
        chk("stl_hold", 32'(if_id_pc), 32'h6);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("rel_instr", if_id_instr, 32'h2800_0007);
        chk("rel_addr", 32'(imem_addr), 32'h8);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("rel_next", if_id_instr, 32'h2C00_0008);
        step(1, 2'b00, 0, 16'h0, 0);
        step(1, 2'b00, 0, 16'h0, 1);
        step(1, 2'b10, 0, 16'h0050, 0);
        chk("full_jmp_valid", 32'(if_id_valid), 32'h0);
        chk("full_jmp_addr", 32'(imem_addr), 32'h50);

        // PC wrap.
        step(0, 2'b10, 0, 16'hFFFF, 1);
        step(0, 2'b00, 0, 16'h0, 1);
        chk("wrap_instr", if_id_instr, 32'h0800_FFFF);
        chk("wrap_addr", 32'(imem_addr), 32'h0);
        step(0, 2'b00, 0, 16'h0, 1);
        step(0, 2'b00, 0, 16'h0, 0);

        // Reset pulse mid-wait.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 2'b00, 0, 16'h0, 1);
        chk("post_rst_pc", 32'(if_id_pc), 32'h3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
